psum_accum_ctrl: RTL and testbench

- Read-modify-write initiator that drives the partial-sum scratchpad's write and read ports inside each PE.
- Accepts MAC products tagged with a psum address and adds each product into the stored psum; the first product of a pass overwrites instead of adding.
- On command, drains psums 0..drain_last out through a valid/ready port toward the PE's psum output path.
- Accounts for the scratchpad's 1-cycle registered read and same-edge write with internal forwarding.

---
 rtl/psum_accum_ctrl_if.sv | 50 +++++
 rtl/psum_accum_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_psum_accum_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_accum_ctrl_if.sv
// ============================================================================
// Module  : psum_accum_ctrl_if
// Purpose : Product, drain, scratchpad and psum-output signal bundle for
//           psum_accum_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface psum_accum_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
);
    logic                  acc_valid;
    logic                  acc_ready;
    logic [DATA_WIDTH-1:0] acc_data;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  acc_first;
    logic                  drain_start;
    logic [ADDR_WIDTH-1:0] drain_last;
    logic                  spad_w_en;
    logic [DATA_WIDTH-1:0] spad_din;
    logic [ADDR_WIDTH-1:0] spad_w_addr;
    logic [ADDR_WIDTH-1:0] spad_r_addr;
    logic [DATA_WIDTH-1:0] spad_dout;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  busy;
    logic                  drain_done;

    // Controller side
    modport master (
        input  acc_valid, acc_data, acc_addr, acc_first,
        input  drain_start, drain_last,
        input  spad_dout, out_ready,
        output acc_ready, spad_w_en, spad_din, spad_w_addr, spad_r_addr,
        output out_valid, out_data, busy, drain_done
    );

    // Environment side: MAC, scratchpad and psum output path
    modport slave (
        output acc_valid, acc_data, acc_addr, acc_first,
        output drain_start, drain_last,
        output spad_dout, out_ready,
        input  acc_ready, spad_w_en, spad_din, spad_w_addr, spad_r_addr,
        input  out_valid, out_data, busy, drain_done
    );
endinterface

`default_nettype wire

// File: rtl/psum_accum_ctrl.sv
// ============================================================================
// Module  : psum_accum_ctrl
// Purpose : Read-modify-write psum accumulator and drain controller for the
//           PE partial-sum scratchpad. Define PSUM_SAT_EN for saturating sums.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_accum_ctrl #(
    parameter int MEM_DEPTH  = 24,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    psum_accum_ctrl_if.master  bus
);

    localparam logic [ADDR_WIDTH-1:0] c_MAX_IDX = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_FLUSH     = 2'd1,
        S_DRAIN_RD  = 2'd2,
        S_DRAIN_OUT = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_a_valid;
    logic [ADDR_WIDTH-1:0] r_a_addr;
    logic [DATA_WIDTH-1:0] r_a_data;
    logic                  r_a_first;

    logic                  r_fwd_valid;
    logic [ADDR_WIDTH-1:0] r_fwd_addr;
    logic [DATA_WIDTH-1:0] r_fwd_data;

    logic [ADDR_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH-1:0] r_last;
    logic                  r_done;

    logic                  w_acc_ready;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_r_addr;
    logic                  w_out_valid;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic [ADDR_WIDTH-1:0] w_idx_nxt;
    logic [ADDR_WIDTH-1:0] w_last_nxt;
    logic                  w_done_nxt;

    logic [DATA_WIDTH-1:0] w_base;
    logic [DATA_WIDTH-1:0] w_addend;
    logic [DATA_WIDTH-1:0] w_sum;

    // ------------------------------------------------------------------------
    // Control FSM: next state and combinational outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_acc_ready = 1'b0;
        w_r_addr    = '0;
        w_out_valid = 1'b0;
        w_out_data  = '0;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_RUN: begin
                w_acc_ready = ~bus.drain_start;
                w_r_addr    = bus.acc_addr;
                if (bus.drain_start) begin
                    w_last_nxt  = (bus.drain_last > c_MAX_IDX) ? c_MAX_IDX : bus.drain_last;
                    w_state_nxt = r_a_valid ? S_FLUSH : S_DRAIN_RD;
                end
            end
            S_FLUSH: begin
                w_state_nxt = S_DRAIN_RD;
            end
            S_DRAIN_RD: begin
                w_r_addr    = r_idx;
                w_state_nxt = S_DRAIN_OUT;
            end
            S_DRAIN_OUT: begin
                w_r_addr    = r_idx;
                w_out_valid = 1'b1;
                w_out_data  = bus.spad_dout;
                if (bus.out_ready) begin
                    if (r_idx == r_last) begin
                        w_idx_nxt   = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_state_nxt = S_DRAIN_RD;
                    end
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    assign w_accept = bus.acc_valid & w_acc_ready;

    // ------------------------------------------------------------------------
    // Stage A datapath. The scratchpad read captured on the accepting edge
    // misses a write landing on that same edge, so the previous write is
    // forwarded when it targets the same address.
    // ------------------------------------------------------------------------
    assign w_base   = (r_fwd_valid && (r_fwd_addr == r_a_addr)) ? r_fwd_data : bus.spad_dout;
    assign w_addend = r_a_first ? '0 : w_base;

`ifdef PSUM_SAT_EN
    logic [DATA_WIDTH:0] w_sum_ext;

    assign w_sum_ext = {w_addend[DATA_WIDTH-1], w_addend} + {r_a_data[DATA_WIDTH-1], r_a_data};

    always_comb begin
        w_sum = w_sum_ext[DATA_WIDTH-1:0];
        if (w_sum_ext[DATA_WIDTH] != w_sum_ext[DATA_WIDTH-1]) begin
            w_sum = w_sum_ext[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                          : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_sum = w_addend + r_a_data;
`endif

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_a_valid   <= 1'b0;
            r_a_addr    <= '0;
            r_a_data    <= '0;
            r_a_first   <= 1'b0;
            r_fwd_valid <= 1'b0;
            r_fwd_addr  <= '0;
            r_fwd_data  <= '0;
            r_idx       <= '0;
            r_last      <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_last      <= w_last_nxt;
            r_done      <= w_done_nxt;
            r_a_valid   <= w_accept;
            if (w_accept) begin
                r_a_addr  <= bus.acc_addr;
                r_a_data  <= bus.acc_data;
                r_a_first <= bus.acc_first;
            end
            r_fwd_valid <= r_a_valid;
            if (r_a_valid) begin
                r_fwd_addr <= r_a_addr;
                r_fwd_data <= w_sum;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.acc_ready   = w_acc_ready;
    assign bus.spad_w_en   = r_a_valid;
    assign bus.spad_w_addr = r_a_valid ? r_a_addr : '0;
    assign bus.spad_din    = r_a_valid ? w_sum : '0;
    assign bus.spad_r_addr = w_r_addr;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_data    = w_out_data;
    assign bus.busy        = (r_state != S_RUN) | r_a_valid;
    assign bus.drain_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_psum_accum_ctrl.sv
// ============================================================================
// Module  : tb_psum_accum_ctrl
// Purpose : Directed self-checking bench for psum_accum_ctrl with a
//           registered-read scratchpad model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psum_accum_ctrl;

`ifdef PSUM_SAT_EN
    localparam logic [15:0] c_OVF_SUM = 16'h7FFF;
`else
    localparam logic [15:0] c_OVF_SUM = 16'hE000;
`endif

    logic clk;
    logic rst_n;

    psum_accum_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) bus ();

    psum_accum_ctrl #(
        .MEM_DEPTH  (24),
        .DATA_WIDTH (16),
        .ADDR_WIDTH (5)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scratchpad: registered read that returns the pre-write value on a collision
    logic [15:0] mem [0:31];
    always @(posedge clk) begin
        if (bus.spad_w_en) mem[bus.spad_w_addr] <= bus.spad_din;
        bus.spad_dout <= mem[bus.spad_r_addr];
    end

    int          n_chk;
    int          n_bad;
    logic [15:0] q_out [$];
    int          leak;
    bit          done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic prod(input logic [4:0] addr, input logic [15:0] data, input logic first);
        bus.acc_valid = 1'b1;
        bus.acc_addr  = addr;
        bus.acc_data  = data;
        bus.acc_first = first;
    endtask

    // Optionally pulses drain_start, then collects words until drain_done
    task automatic run_drain(input logic [4:0] last, input bit pulse);
        q_out.delete();
        leak = 0;
        done = 1'b0;
        if (pulse) begin
            bus.drain_last  = last;
            bus.drain_start = 1'b1;
            @(negedge clk);
            bus.drain_start = 1'b0;
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (bus.drain_done) begin
                done = 1'b1;
                break;
            end
            if (bus.acc_ready) leak++;
            if (bus.out_valid) q_out.push_back(bus.out_data);
            @(negedge clk);
        end
        chk("drain_done_seen", {31'd0, done}, 32'd1);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        for (int i = 0; i < 32; i++) mem[i] = 16'h0;
        rst_n           = 1'b0;
        bus.acc_valid   = 1'b0;
        bus.acc_addr    = '0;
        bus.acc_data    = '0;
        bus.acc_first   = 1'b0;
        bus.drain_start = 1'b0;
        bus.drain_last  = '0;
        bus.out_ready   = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_acc_ready", {31'd0, bus.acc_ready}, 32'd1);
        chk("rst_w_en",      {31'd0, bus.spad_w_en}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, bus.busy}, 32'd0);
        chk("rst_done",      {31'd0, bus.drain_done}, 32'd0);
        chk("rst_w_addr",    {27'd0, bus.spad_w_addr}, 32'd0);
        chk("rst_din",       {16'd0, bus.spad_din}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Same-address back-to-back products use forwarding
        @(negedge clk);
        prod(5'd3, 16'd5, 1'b1);
        @(negedge clk);
        prod(5'd3, 16'd7, 1'b0);
        #1;
        chk("t1_w_en1",   {31'd0, bus.spad_w_en}, 32'd1);
        chk("t1_w_addr1", {27'd0, bus.spad_w_addr}, 32'd3);
        chk("t1_din1",    {16'd0, bus.spad_din}, 32'd5);
        @(negedge clk);
        bus.acc_valid = 1'b0;
        #1;
        chk("t1_din2", {16'd0, bus.spad_din}, 32'd12);
        chk("t1_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        #1;
        chk("t1_idle_w_en", {31'd0, bus.spad_w_en}, 32'd0);
        chk("t1_idle_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        run_drain(5'd3, 1'b1);
        chk("t1_cnt",  q_out.size(), 32'd4);
        chk("t1_idx3", (q_out.size() > 3) ? {16'd0, q_out[3]} : 32'hDEAD, 32'd12);

        // Interleaved addresses
        @(negedge clk);
        prod(5'd0, 16'd1, 1'b1);
        @(negedge clk);
        prod(5'd1, 16'd2, 1'b1);
        @(negedge clk);
        prod(5'd0, 16'd3, 1'b0);
        @(negedge clk);
        prod(5'd1, 16'd4, 1'b0);
        @(negedge clk);
        bus.acc_valid = 1'b0;
        #1;
        chk("t2_last_din", {16'd0, bus.spad_din}, 32'd6);
        @(negedge clk);
        run_drain(5'd1, 1'b1);
        chk("t2_cnt", q_out.size(), 32'd2);
        chk("t2_o0", (q_out.size() > 0) ? {16'd0, q_out[0]} : 32'hDEAD, 32'd4);
        chk("t2_o1", (q_out.size() > 1) ? {16'd0, q_out[1]} : 32'hDEAD, 32'd6);

        // Back-pressure on index 0
        @(negedge clk);
        bus.out_ready   = 1'b0;
        bus.drain_last  = 5'd0;
        bus.drain_start = 1'b1;
        @(negedge clk);
        bus.drain_start = 1'b0;
        #1;
        chk("t3_rd_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("t3_hold_data",  {16'd0, bus.out_data}, 32'd4);
            chk("t3_hold_raddr", {27'd0, bus.spad_r_addr}, 32'd0);
            chk("t3_hold_done",  {31'd0, bus.drain_done}, 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("t3_rel_valid", {31'd0, bus.out_valid}, 32'd1);
        @(negedge clk);
        #1;
        chk("t3_done",      {31'd0, bus.drain_done}, 32'd1);
        chk("t3_done_oval", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("t3_done_pulse", {31'd0, bus.drain_done}, 32'd0);
        chk("t3_acc_ready",  {31'd0, bus.acc_ready}, 32'd1);

        // drain_start the cycle after an accepted product
        @(negedge clk);
        prod(5'd1, 16'd10, 1'b0);
        @(negedge clk);
        bus.acc_valid   = 1'b0;
        bus.drain_last  = 5'd1;
        bus.drain_start = 1'b1;
        #1;
        chk("t4_ready_lo", {31'd0, bus.acc_ready}, 32'd0);
        chk("t4_din",      {16'd0, bus.spad_din}, 32'd16);
        @(negedge clk);
        bus.drain_start = 1'b0;
        #1;
        chk("t4_flush_busy",  {31'd0, bus.busy}, 32'd1);
        chk("t4_flush_ready", {31'd0, bus.acc_ready}, 32'd0);
        chk("t4_flush_oval",  {31'd0, bus.out_valid}, 32'd0);
        run_drain(5'd1, 1'b0);
        chk("t4_cnt",  q_out.size(), 32'd2);
        chk("t4_o1",   (q_out.size() > 1) ? {16'd0, q_out[1]} : 32'hDEAD, 32'd16);
        chk("t4_leak", leak, 32'd0);

        // Overflow: wrap or saturate
        @(negedge clk);
        prod(5'd2, 16'h7000, 1'b1);
        @(negedge clk);
        prod(5'd2, 16'h7000, 1'b0);
        #1;
        chk("t5_din1", {16'd0, bus.spad_din}, 32'h7000);
        @(negedge clk);
        bus.acc_valid = 1'b0;
        #1;
        chk("t5_din2", {16'd0, bus.spad_din}, {16'd0, c_OVF_SUM});
        @(negedge clk);

        // Reset during DRAIN_OUT, then an over-range drain_last
        bus.out_ready   = 1'b0;
        bus.drain_last  = 5'd5;
        bus.drain_start = 1'b1;
        @(negedge clk);
        bus.drain_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (bus.out_valid) break;
        end
        chk("t6_reached_out", {31'd0, bus.out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_oval",  {31'd0, bus.out_valid}, 32'd0);
        chk("t6_rst_busy",  {31'd0, bus.busy}, 32'd0);
        chk("t6_rst_ready", {31'd0, bus.acc_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("t6_post_ready", {31'd0, bus.acc_ready}, 32'd1);
        @(negedge clk);
        run_drain(5'd30, 1'b1);
        chk("t6_cnt", q_out.size(), 32'd24);
        chk("t6_o2",  (q_out.size() > 2) ? {16'd0, q_out[2]} : 32'hDEAD, {16'd0, c_OVF_SUM});
        chk("t6_o3",  (q_out.size() > 3) ? {16'd0, q_out[3]} : 32'hDEAD, 32'd12);
        chk("t6_o23", (q_out.size() > 23) ? {16'd0, q_out[23]} : 32'hDEAD, 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
